// File: rtl/hack_pkg.sv
// Shared types and widths for the Hack ROM loader.
package hack_pkg;

    localparam int unsigned ROM_ADDR_W = 15;
    localparam int unsigned WORD_W     = 16;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned LEN_W      = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA_HI,
        ST_DATA_LO,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } loader_state_e;

    typedef struct packed {
        logic [ROM_ADDR_W-1:0] addr;
        logic [WORD_W-1:0]     data;
    } rom_wr_t;

endpackage

// File: rtl/hack_word_assembler.sv
// Holds the high byte of the word in flight and the running XOR of data bytes.
module hack_word_assembler
    import hack_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              hi_en,
    input  logic              lo_en,
    input  logic [BYTE_W-1:0] in_byte,
    output logic [WORD_W-1:0] word_c,
    output logic [BYTE_W-1:0] csum
);

    logic [BYTE_W-1:0] hi_q, hi_d;
    logic [BYTE_W-1:0] csum_q, csum_d;

    always_comb begin
        hi_d   = hi_q;
        csum_d = csum_q;
        if (clear) begin
            hi_d   = '0;
            csum_d = '0;
        end else begin
            if (hi_en) begin
                hi_d = in_byte;
            end
            if (hi_en || lo_en) begin
                csum_d = csum_q ^ in_byte;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hi_q   <= '0;
            csum_q <= '0;
        end else begin
            hi_q   <= hi_d;
            csum_q <= csum_d;
        end
    end

    // Low byte comes straight from the bus so the word is ready on the DATA_LO transfer.
    assign word_c = {hi_q, in_byte};
    assign csum   = csum_q;

endmodule

// File: rtl/hack_rom_loader.sv
// Serial program loader: parses length/data/checksum bytes and writes words into Hack ROM.
module hack_rom_loader
    import hack_pkg::*;
#(
    parameter int unsigned MAX_WORDS = 32768
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [BYTE_W-1:0]     in_byte,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    output logic [WORD_W-1:0]     rom_data,
    output logic                  rom_we,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  cpu_reset
);

    loader_state_e     state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  word_cnt_q, word_cnt_d;
    rom_wr_t           wr_q, wr_d;
    logic              rom_we_q, rom_we_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic              xfer;
    logic              asm_clear, asm_hi_en, asm_lo_en;
    logic [WORD_W-1:0] asm_word_c;
    logic [BYTE_W-1:0] asm_csum;
    logic [LEN_W-1:0]  len_new;
    logic [LEN_W-1:0]  word_cnt_inc;

    assign xfer         = in_valid && in_ready_q;
    assign len_new      = {len_q[LEN_W-1:BYTE_W], in_byte};
    assign word_cnt_inc = word_cnt_q + LEN_W'(1);

    hack_word_assembler u_asm (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (asm_clear),
        .hi_en   (asm_hi_en),
        .lo_en   (asm_lo_en),
        .in_byte (in_byte),
        .word_c  (asm_word_c),
        .csum    (asm_csum)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        wr_d       = wr_q;
        rom_we_d   = 1'b0;
        asm_clear  = 1'b0;
        asm_hi_en  = 1'b0;
        asm_lo_en  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d    = ST_LEN_HI;
                    len_d      = '0;
                    word_cnt_d = '0;
                    wr_d.addr  = '0;
                    asm_clear  = 1'b1;
                end
            end
            ST_LEN_HI: begin
                if (xfer) begin
                    len_d   = {in_byte, len_q[BYTE_W-1:0]};
                    state_d = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (xfer) begin
                    len_d = len_new;
                    if (len_new == '0) begin
                        state_d = ST_CHECK;
                    end else if (32'(len_new) > MAX_WORDS) begin
                        state_d = ST_ERROR;
                    end else begin
                        state_d = ST_DATA_HI;
                    end
                end
            end
            ST_DATA_HI: begin
                if (xfer) begin
                    asm_hi_en = 1'b1;
                    state_d   = ST_DATA_LO;
                end
            end
            ST_DATA_LO: begin
                if (xfer) begin
                    asm_lo_en  = 1'b1;
                    wr_d.addr  = word_cnt_q[ROM_ADDR_W-1:0];
                    wr_d.data  = asm_word_c;
                    rom_we_d   = 1'b1;
                    word_cnt_d = word_cnt_inc;
                    state_d    = (word_cnt_inc == len_q) ? ST_CHECK : ST_DATA_HI;
                end
            end
            ST_CHECK: begin
                if (xfer) begin
                    state_d = (in_byte == asm_csum) ? ST_DONE : ST_ERROR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status flags are registered copies of the next-state decode.
        in_ready_d = state_d inside {ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO, ST_CHECK};
        busy_d     = in_ready_d;
        done_d     = (state_d == ST_DONE);
        error_d    = (state_d == ST_ERROR);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            word_cnt_q <= '0;
            wr_q       <= '0;
            rom_we_q   <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            wr_q       <= wr_d;
            rom_we_q   <= rom_we_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign rom_addr  = wr_q.addr;
    assign rom_data  = wr_q.data;
    assign rom_we    = rom_we_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign cpu_reset = busy_q;

endmodule

// File: tb/tb_hack_rom_loader.sv
// Directed bench for hack_rom_loader: normal, empty, bad checksum, oversize, stall/abort, ignored start.
module tb_hack_rom_loader;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic [14:0] rom_addr;
    logic [15:0] rom_data;
    logic        rom_we;
    logic        busy;
    logic        done;
    logic        error;
    logic        cpu_reset;

    int checks;
    int failures;

    logic [14:0] wa[$];
    logic [15:0] wd[$];

    hack_rom_loader #(.MAX_WORDS(32768)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .in_byte   (in_byte),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .rom_we    (rom_we),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .cpu_reset (cpu_reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log every write strobe seen mid-cycle.
    always @(negedge clk) begin
        if (rom_we === 1'b1) begin
            wa.push_back(rom_addr);
            wd.push_back(rom_data);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Status vector {in_ready, busy, cpu_reset, done, error}.
    task automatic chk_st(input string tag, input logic [4:0] exp);
        chk(tag, 32'({in_ready, busy, cpu_reset, done, error}), 32'(exp));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        in_byte  = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic gap(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
    endtask

    task automatic chk_norm_writes(input string tag);
        chk({tag, "_nwr"}, 32'(wa.size()), 32'd2);
        if (wa.size() == 2) begin
            chk({tag, "_a0"}, 32'(wa[0]), 32'h0);
            chk({tag, "_d0"}, 32'(wd[0]), 32'h1234);
            chk({tag, "_a1"}, 32'(wa[1]), 32'h1);
            chk({tag, "_d1"}, 32'(wd[1]), 32'hABCD);
        end
        clear_log();
    endtask

    task automatic normal_stream(input logic [7:0] ck);
        send(8'h00); send(8'h02);
        send(8'h12); send(8'h34);
        send(8'hAB); send(8'hCD);
        send(ck);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        start    = 1'b0;
        in_byte  = 8'h00;
        in_valid = 1'b0;
        tick(); tick();
        chk_st("reset_status", 5'b00000);
        chk("reset_we", 32'(rom_we), 32'd0);
        chk("reset_addr", 32'(rom_addr), 32'd0);
        chk("reset_data", 32'(rom_data), 32'd0);
        reset_n = 1'b1;
        tick();
        chk_st("idle_status", 5'b00000);
        clear_log();

        // Normal load: checksum 12^34^AB^CD = 40.
        pulse_start();
        chk_st("norm_busy", 5'b11100);
        normal_stream(8'h40);
        chk_st("norm_done", 5'b00010);
        chk_norm_writes("norm");

        // Start with a byte offered in DONE: byte must not be consumed.
        in_byte  = 8'h00;
        in_valid = 1'b1;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        chk_st("restart_busy", 5'b11100);
        normal_stream(8'h40);
        chk_st("restart_done", 5'b00010);
        chk_norm_writes("restart");

        // Empty load.
        pulse_start();
        send(8'h00); send(8'h00);
        chk_st("empty_check", 5'b11100);
        send(8'h00);
        chk_st("empty_done", 5'b00010);
        chk("empty_nwr", 32'(wa.size()), 32'd0);
        clear_log();

        // Bad checksum.
        pulse_start();
        normal_stream(8'h41);
        chk_st("badck_err", 5'b00001);
        chk_norm_writes("badck");

        // Oversize length 0x8001.
        pulse_start();
        send(8'h80);
        chk_st("over_lenlo", 5'b11100);
        send(8'h01);
        chk_st("over_err", 5'b00001);
        tick();
        chk("over_nwr", 32'(wa.size()), 32'd0);
        clear_log();

        // Boundary length 0x8000 is accepted, then aborted by reset.
        pulse_start();
        send(8'h80); send(8'h00);
        chk_st("max_accept", 5'b11100);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk_st("max_reset", 5'b00000);
        clear_log();

        // Stall gaps, then reset in DATA_LO together with a valid low byte.
        pulse_start();
        send(8'h00);
        gap(3);
        chk_st("stall_lenlo", 5'b11100);
        send(8'h02);
        send(8'h12);
        gap(3);
        chk_st("stall_datalo", 5'b11100);
        chk("stall_nwr0", 32'(wa.size()), 32'd0);
        send(8'h34);
        gap(3);
        chk("stall_nwr1", 32'(wa.size()), 32'd1);
        chk("stall_we_low", 32'(rom_we), 32'd0);
        send(8'hAB);
        in_byte  = 8'hCD;
        in_valid = 1'b1;
        reset_n  = 1'b0;
        tick();
        in_valid = 1'b0;
        chk_st("abort_status", 5'b00000);
        chk("abort_we", 32'(rom_we), 32'd0);
        chk("abort_addr", 32'(rom_addr), 32'd0);
        chk("abort_data", 32'(rom_data), 32'd0);
        reset_n = 1'b1;
        tick();
        chk("abort_nwr", 32'(wa.size()), 32'd1);
        clear_log();
        pulse_start();
        normal_stream(8'h40);
        chk_st("after_abort_done", 5'b00010);
        chk_norm_writes("after_abort");

        // Start pulsed during DATA_HI is ignored.
        pulse_start();
        send(8'h00); send(8'h02);
        send(8'h12); send(8'h34);
        pulse_start();
        chk_st("ign_start_busy", 5'b11100);
        send(8'hAB); send(8'hCD);
        send(8'h40);
        chk_st("ign_start_done", 5'b00010);
        chk_norm_writes("ign_start");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
